instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
// - Decoupling FIFO between instrFetchUnit and instr_decode.
// - Fetch pushes one instruction bundle per cycle: instr, instrPC, predicted PC, GHR index, PHT state and redirect flag.
// - Decode pops bundles in order; a decode stall (ROB or reservation station full) does not stall fetch until the queue fills.
// - Flushed on ROB misprediction (controlFlow[0]) or on a rename-stage JAL redirect.
// PARAMETERS
// - WIDTH  31  MSB index of data/address words (32-bit).
// - INDEX  7   MSB index of GHR index field.
// - DEPTH  4   number of entries; power of two, >=2.
// - PTR    1   MSB index of read/write pointers; equals log2(DEPTH)-1.
// PORTS
// - clk            in   1        rising-edge clock.
// - globalResetN   in   1        asynchronous, active-low reset.
// - fetchValid     in   1        fetch presents a valid bundle.
// - fetchReady     out  1        queue can accept a push (= !full).
// - fInstr         in   WIDTH+1  instruction word.
// - fPC            in   WIDTH+1  instruction PC.
// - fPredPC        in   WIDTH+1  predicted next PC.
// - fGHRIndex      in   INDEX+1  gshare index used for prediction.
// - fPHTState      in   2        PHT counter state read.
// - fRedirect      in   1        predictor redirected flow.
// - decodeValid    out  1        head bundle valid.
// - decodeReady    in   1        decode consumes head this cycle.
// - dInstr, dPC, dPredPC, dGHRIndex, dPHTState, dRedirect  out  as f*  head bundle fields.
// - flush          in   1        ROB misprediction (controlFlow[0]).
// - earlyFlush     in   1        rename-stage JAL redirect.
// - occupancy      out  PTR+2    current entry count, 0..DEPTH.
// - freeze         out  1        full; fetch holds PC.
// BEHAVIOUR
// - Reset (async, globalResetN=0):
//   - pointers, count = 0; decodeValid = 0; fetchReady = 1; freeze = 0.
//   - All d* outputs = 0 (storage cleared).
//   - Reset mid-operation discards all entries immediately.
// - push = fetchValid & fetchReady; pop = decodeValid & decodeReady.
//   - On push: write mem[wrPtr], wrPtr++ (wraps DEPTH-1 -> 0).
//   - On pop: rdPtr++ (wraps).
// - Count:
//   - +1 on push only, -1 on pop only.
//   - Unchanged on simultaneous push & pop, including at count==1.
// - fetchReady = (count != DEPTH). No push-through-when-full, even with a same-cycle pop.
// - decodeValid = (count != 0). d* = mem[rdPtr], combinational read of the register array.
// - Latency: a push into an empty queue appears on d* in the next cycle (1 cycle).
// - Flush (flush | earlyFlush), sampled at the clock edge:
//   - Next state is empty; pointers reset to 0.
//   - A same-cycle push is dropped; a same-cycle pop has no effect beyond the flush.
//   - Flush has priority over push and pop.
// - freeze = !fetchReady. occupancy = count.
// - d* are don't-care while decodeValid=0; the bench must not check them then.
// - No overflow or underflow is possible: a push when full and a pop when empty are ignored by construction.
// CONFIGURATION
// - IFQ_BYPASS_EN defined: when the queue is empty, fetchValid=1, decodeReady=1 and no flush:
//   - f* drive d* combinationally and decodeValid=1.
//   - The bundle is consumed in the same cycle (0 latency); nothing is written and count stays 0.
// - IFQ_BYPASS_EN undefined: no combinational f->d path; latency is always 1 cycle.
// TESTING
// - Reset: hold globalResetN=0 for 2 cycles -> decodeValid=0, fetchReady=1, occupancy=0, dInstr=0.
// - Fill: push 4 bundles (instrPC 0x00,0x04,0x08,0x0C) with decodeReady=0 -> occupancy=4, freeze=1, and a 5th push is ignored.
// - Drain order: from full, decodeReady=1 for 4 cycles -> dPC sequence 0x00,0x04,0x08,0x0C, then decodeValid=0.
// - Wrap: 10 cycles of simultaneous push & pop at occupancy 1 -> occupancy stays 1 and PCs emerge in order across the pointer wrap.
// - Flush: occupancy 3, assert flush together with a push of 0x40 -> next cycle occupancy=0 and 0x40 never appears.
// - Bypass (IFQ_BYPASS_EN): empty queue, push 0x80 with decodeReady=1 -> dPC=0x80 in the same cycle and occupancy remains 0.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: in-order decoupling FIFO between the fetch unit and decode.
// Each entry holds one fetch bundle: instruction, PC, predicted PC, GHR index,
// PHT state and redirect flag. flush / earlyFlush empty the queue at the next edge.
// Optional feature macro: IFQ_BYPASS_EN. When it is defined, a bundle offered to
// an empty queue while decode is ready passes straight through with 0 latency.
module instr_fetch_queue #(
    parameter int WIDTH = 31,
    parameter int INDEX = 7,
    parameter int DEPTH = 4,
    parameter int PTR   = 1
) (
    input  logic             clk,
    input  logic             globalResetN,
    input  logic             fetchValid,
    output logic             fetchReady,
    input  logic [WIDTH:0]   fInstr,
    input  logic [WIDTH:0]   fPC,
    input  logic [WIDTH:0]   fPredPC,
    input  logic [INDEX:0]   fGHRIndex,
    input  logic [1:0]       fPHTState,
    input  logic             fRedirect,
    output logic             decodeValid,
    input  logic             decodeReady,
    output logic [WIDTH:0]   dInstr,
    output logic [WIDTH:0]   dPC,
    output logic [WIDTH:0]   dPredPC,
    output logic [INDEX:0]   dGHRIndex,
    output logic [1:0]       dPHTState,
    output logic             dRedirect,
    input  logic             flush,
    input  logic             earlyFlush,
    output logic [PTR+1:0]   occupancy,
    output logic             freeze
);

    localparam logic [PTR:0]   PTR_ONE  = (PTR+1)'(1);
    localparam logic [PTR+1:0] CNT_ONE  = (PTR+2)'(1);
    localparam logic [PTR+1:0] CNT_FULL = (PTR+2)'(DEPTH);

    logic [WIDTH:0] mem_instr_q  [DEPTH];
    logic [WIDTH:0] mem_pc_q     [DEPTH];
    logic [WIDTH:0] mem_pred_q   [DEPTH];
    logic [INDEX:0] mem_ghr_q    [DEPTH];
    logic [1:0]     mem_pht_q    [DEPTH];
    logic           mem_redir_q  [DEPTH];

    logic [PTR:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR+1:0] count_q, count_d;

    logic flush_any;
    logic empty;
    logic bypass;
    logic push;
    logic pop;

    assign flush_any = flush | earlyFlush;
    assign empty     = (count_q == '0);

`ifdef IFQ_BYPASS_EN
    assign bypass = empty & fetchValid & decodeReady & ~flush_any;
`else
    assign bypass = 1'b0;
`endif

    assign fetchReady  = (count_q != CNT_FULL);
    assign freeze      = ~fetchReady;
    assign occupancy   = count_q;
    // A bypassed bundle is consumed directly, so it is neither written nor popped.
    assign push        = fetchValid & fetchReady & ~bypass;
    assign pop         = ~empty & decodeReady;
    assign decodeValid = ~empty | bypass;

    // Head bundle: combinational read of the entry at the read pointer (or bypass).
    always_comb begin
        dInstr    = mem_instr_q[rd_ptr_q];
        dPC       = mem_pc_q[rd_ptr_q];
        dPredPC   = mem_pred_q[rd_ptr_q];
        dGHRIndex = mem_ghr_q[rd_ptr_q];
        dPHTState = mem_pht_q[rd_ptr_q];
        dRedirect = mem_redir_q[rd_ptr_q];
        if (bypass) begin
            dInstr    = fInstr;
            dPC       = fPC;
            dPredPC   = fPredPC;
            dGHRIndex = fGHRIndex;
            dPHTState = fPHTState;
            dRedirect = fRedirect;
        end
    end

    // Pointer and count next state; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_any) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      count_d = count_q + CNT_ONE;
            else if (pop && !push) count_d = count_q - CNT_ONE;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge globalResetN) begin
        if (!globalResetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk or negedge globalResetN) begin
        if (!globalResetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_q[i] <= '0;
                mem_pc_q[i]    <= '0;
                mem_pred_q[i]  <= '0;
                mem_ghr_q[i]   <= '0;
                mem_pht_q[i]   <= '0;
                mem_redir_q[i] <= 1'b0;
            end
        end else if (push && !flush_any) begin
            mem_instr_q[wr_ptr_q] <= fInstr;
            mem_pc_q[wr_ptr_q]    <= fPC;
            mem_pred_q[wr_ptr_q]  <= fPredPC;
            mem_ghr_q[wr_ptr_q]   <= fGHRIndex;
            mem_pht_q[wr_ptr_q]   <= fPHTState;
            mem_redir_q[wr_ptr_q] <= fRedirect;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        globalResetN;
    logic        fetchValid;
    logic        fetchReady;
    logic [31:0] fInstr, fPC, fPredPC;
    logic [7:0]  fGHRIndex;
    logic [1:0]  fPHTState;
    logic        fRedirect;
    logic        decodeValid;
    logic        decodeReady;
    logic [31:0] dInstr, dPC, dPredPC;
    logic [7:0]  dGHRIndex;
    logic [1:0]  dPHTState;
    logic        dRedirect;
    logic        flush, earlyFlush;
    logic [2:0]  occupancy;
    logic        freeze;

    int n_assert = 0;
    int n_fail   = 0;

    instr_fetch_queue dut (
        .clk(clk), .globalResetN(globalResetN),
        .fetchValid(fetchValid), .fetchReady(fetchReady),
        .fInstr(fInstr), .fPC(fPC), .fPredPC(fPredPC),
        .fGHRIndex(fGHRIndex), .fPHTState(fPHTState), .fRedirect(fRedirect),
        .decodeValid(decodeValid), .decodeReady(decodeReady),
        .dInstr(dInstr), .dPC(dPC), .dPredPC(dPredPC),
        .dGHRIndex(dGHRIndex), .dPHTState(dPHTState), .dRedirect(dRedirect),
        .flush(flush), .earlyFlush(earlyFlush),
        .occupancy(occupancy), .freeze(freeze)
    );

    always #5 clk = ~clk;

    // Bundle fields are all derived from the PC so expectations can be rebuilt.
    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction
    function automatic logic [7:0] ghr_of(input logic [31:0] pc);
        return pc[7:0] ^ 8'h3C;
    endfunction

    task automatic offer(input logic v, input logic [31:0] pc);
        fetchValid = v;
        fPC        = pc;
        fInstr     = instr_of(pc);
        fPredPC    = pc + 32'd4;
        fGHRIndex  = ghr_of(pc);
        fPHTState  = pc[3:2];
        fRedirect  = pc[2];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        globalResetN = 1'b0;
        decodeReady  = 1'b0;
        flush        = 1'b0;
        earlyFlush   = 1'b0;
        offer(1'b0, 32'h0);

        // Reset state
        step(); step();
        chk("rst_decodeValid", 32'(decodeValid), 32'd0);
        chk("rst_fetchReady",  32'(fetchReady),  32'd1);
        chk("rst_occupancy",   32'(occupancy),   32'd0);
        chk("rst_dInstr",      dInstr,           32'd0);
        chk("rst_freeze",      32'(freeze),      32'd0);
        globalResetN = 1'b1;
        step();

        // Fill with 4 bundles, decode stalled
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 32'(4 * i));
            step();
        end
        chk("fill_occupancy",  32'(occupancy),   32'd4);
        chk("fill_freeze",     32'(freeze),      32'd1);
        chk("fill_fetchReady", 32'(fetchReady),  32'd0);
        chk("fill_head_pc",    dPC,              32'h00);
        // 5th push ignored
        offer(1'b1, 32'h10);
        step();
        chk("full_push_occ",   32'(occupancy),   32'd4);

        // Drain in order
        offer(1'b0, 32'h0);
        decodeReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(decodeValid), 32'd1);
            chk("drain_pc",    dPC,              32'(4 * i));
            chk("drain_instr", dInstr,           instr_of(32'(4 * i)));
            chk("drain_pred",  dPredPC,          32'(4 * i + 4));
            chk("drain_ghr",   32'(dGHRIndex),   32'(ghr_of(32'(4 * i))));
            chk("drain_pht",   32'(dPHTState),   32'(i % 4));
            chk("drain_redir", 32'(dRedirect),   32'(i % 2));
            step();
        end
        chk("drain_empty_valid", 32'(decodeValid), 32'd0);
        chk("drain_empty_occ",   32'(occupancy),   32'd0);
        chk("drain_fetchReady",  32'(fetchReady),  32'd1);

        // Wrap: simultaneous push & pop at occupancy 1
        decodeReady = 1'b0;
        offer(1'b1, 32'h100);
        step();
        chk("wrap_start_occ", 32'(occupancy), 32'd1);
        decodeReady = 1'b1;
        for (int k = 0; k < 10; k++) begin
            offer(1'b1, 32'(32'h104 + 4 * k));
            chk("wrap_valid", 32'(decodeValid), 32'd1);
            chk("wrap_pc",    dPC,              32'(32'h100 + 4 * k));
            step();
            chk("wrap_occ",   32'(occupancy),   32'd1);
        end
        offer(1'b0, 32'h0);
        chk("wrap_last_pc", dPC, 32'h128);
        step();
        chk("wrap_drained", 32'(occupancy), 32'd0);

        // Flush with same-cycle push
        decodeReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, 32'(32'h20 + 4 * i));
            step();
        end
        chk("flush_pre_occ", 32'(occupancy), 32'd3);
        offer(1'b1, 32'h40);
        flush = 1'b1;
        step();
        flush = 1'b0;
        offer(1'b0, 32'h0);
        chk("flush_occ",   32'(occupancy),   32'd0);
        chk("flush_valid", 32'(decodeValid), 32'd0);
        step();
        chk("flush_stays_empty", 32'(occupancy), 32'd0);
        offer(1'b1, 32'h44);
        step();
        offer(1'b0, 32'h0);
        chk("post_flush_head", dPC, 32'h44);

        // Early flush with same-cycle pop
        decodeReady = 1'b1;
        earlyFlush  = 1'b1;
        step();
        earlyFlush  = 1'b0;
        chk("eflush_occ", 32'(occupancy), 32'd0);

        // Full with same-cycle pop: push must still be refused
        decodeReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 32'(32'h200 + 4 * i));
            step();
        end
        offer(1'b1, 32'h99);
        decodeReady = 1'b1;
        step();
        offer(1'b0, 32'h0);
        decodeReady = 1'b0;
        chk("full_pop_occ",  32'(occupancy), 32'd3);
        chk("full_pop_head", dPC,            32'h204);

        // Async reset mid-operation
        #2;
        globalResetN = 1'b0;
        #1;
        chk("midrst_occ",   32'(occupancy),   32'd0);
        chk("midrst_valid", 32'(decodeValid), 32'd0);
        step();
        globalResetN = 1'b1;
        step();

        // Empty queue, push 0x80 with decode ready
        decodeReady = 1'b1;
        offer(1'b1, 32'h80);
        #1;
`ifdef IFQ_BYPASS_EN
        chk("bypass_valid", 32'(decodeValid), 32'd1);
        chk("bypass_pc",    dPC,              32'h80);
        step();
        offer(1'b0, 32'h0);
        chk("bypass_occ",   32'(occupancy),   32'd0);
`else
        chk("nobypass_valid", 32'(decodeValid), 32'd0);
        step();
        offer(1'b0, 32'h0);
        chk("nobypass_occ",   32'(occupancy),   32'd1);
        chk("nobypass_pc",    dPC,              32'h80);
        step();
        chk("nobypass_drain", 32'(occupancy),   32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
